// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: SYNC, LEN, payload, CHK -> buffered valid/ready stream.
// Bad length, bad checksum and inter-byte stalls drop the frame with a pulse.
module uart_rx_frame_ctrl #(
    parameter int         CLK_Hz       = 66_000_000,
    parameter int         BITRATE_bps  = 9_600,
    parameter int         TIMEOUT_BITS = 20,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       overrun,
    output logic       busy
);

    localparam int TIMEOUT_CLKS = CLK_Hz / BITRATE_bps * TIMEOUT_BITS;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_B   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_len;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [7:0]      r_chk;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_buf [MAX_LEN];
    logic [7:0]      r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic            r_frame_ok;
    logic            r_err_chk;
    logic            r_err_len;
    logic            r_err_timeout;
    logic            r_overrun;

    logic            w_len_ok;
    logic            w_wr_last;
    logic            w_rd_last;
    logic [PW-1:0]   w_rd_next;
    logic            w_rd_next_last;
    logic            w_xfer;
    logic            w_to_hit;
    logic            w_in_frame;
    logic            w_buf_we;

    assign w_len_ok       = (rx_data != 8'd0) && (rx_data <= MAX_B);
    assign w_wr_last      = (LW'(r_wr_ptr) == r_len - 1'b1);
    assign w_rd_last      = (LW'(r_rd_ptr) == r_len - 1'b1);
    assign w_rd_next      = r_rd_ptr + 1'b1;
    assign w_rd_next_last = (LW'(w_rd_next) == r_len - 1'b1);
    assign w_xfer         = r_m_valid && m_ready;
    assign w_to_hit       = (r_to_cnt == TO_LAST);
    assign w_in_frame     = (r_state == S_LEN) || (r_state == S_PAYLOAD) ||
                            (r_state == S_CHK);
    assign w_buf_we       = (r_state == S_PAYLOAD) && rx_valid;

    // Payload store carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_HUNT;
            r_len         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_chk         <= '0;
            r_to_cnt      <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_ok    <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_overrun     <= 1'b0;
            unique case (r_state)
                S_HUNT: begin
                    if (rx_valid && rx_data == SYNC) begin
                        r_state  <= S_LEN;
                        r_to_cnt <= '0;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (w_len_ok) begin
                            r_len    <= rx_data[LW-1:0];
                            r_chk    <= rx_data;
                            r_wr_ptr <= '0;
                            r_state  <= S_PAYLOAD;
                        end else begin
                            r_err_len <= 1'b1;
                            r_state   <= S_HUNT;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        r_chk <= r_chk ^ rx_data;
                        if (w_wr_last) begin
                            r_state <= S_CHK;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == r_chk) begin
                            r_frame_ok <= 1'b1;
                            r_m_valid  <= 1'b1;
                            r_m_data   <= r_buf[0];
                            r_m_last   <= (r_len == LW'(1));
                            r_rd_ptr   <= '0;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_err_chk <= 1'b1;
                            r_state   <= S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_rd_last) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_state   <= S_HUNT;
                        end else begin
                            r_rd_ptr <= w_rd_next;
                            r_m_data <= r_buf[w_rd_next];
                            r_m_last <= w_rd_next_last;
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
            // An arriving byte always beats the stall limit on the same cycle.
            if (w_in_frame) begin
                if (rx_valid) begin
                    r_to_cnt <= '0;
                end else if (w_to_hit) begin
                    r_err_timeout <= 1'b1;
                    r_state       <= S_HUNT;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign frame_ok    = r_frame_ok;
    assign err_chk     = r_err_chk;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames plus random frames
// scored against a frame-level model (length rule, XOR checksum, payload).
module tb_uart_rx_frame_ctrl;

    localparam int CLK_HZ  = 96_000;
    localparam int BAUD    = 9_600;
    localparam int TO_BITS = 20;
    localparam int MAXL    = 16;
    localparam int TO_CLKS = (CLK_HZ / BAUD) * TO_BITS;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;
    logic       busy;

    uart_rx_frame_ctrl #(
        .CLK_Hz      (CLK_HZ),
        .BITRATE_bps (BAUD),
        .TIMEOUT_BITS(TO_BITS),
        .MAX_LEN     (MAXL),
        .SYNC        (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_ok   (frame_ok),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         cyc;
    } xfer_t;

    xfer_t xq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_ok, n_chk, n_len, n_to, n_ovr;
    int n_multi = 0;
    int ok_cyc, to_cyc, last_strobe;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) begin
                n_ok++;
                ok_cyc = cyc;
            end
            if (err_chk) n_chk++;
            if (err_len) n_len++;
            if (err_timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            if (overrun) n_ovr++;
            if (int'(frame_ok) + int'(err_chk) + int'(err_len) +
                int'(err_timeout) + int'(overrun) > 1) n_multi++;
            if (m_valid && m_ready) xq.push_back('{m_data, m_last, cyc});
        end
    end

    task automatic clear_mon();
        n_ok = 0; n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0;
        xq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        last_strobe = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        idle(2);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({m_data, m_valid, m_last, frame_ok, err_chk, err_len,
             err_timeout, overrun, busy} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {m_data, m_valid, m_last, frame_ok, err_chk, err_len,
                      err_timeout, overrun, busy});
        end
        idle(2);
        rst = 1'b0;
        idle(2);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d[3];
        bit ok;
        bit bad_d;
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
        clear_mon();
        m_ready = 1'b1;
        send_byte(SYNC); send_byte(8'h03);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA3);
        wait_idle(50, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL good_idle: busy stuck high"); end
        n_cmp++;
        if (n_ok !== 1) begin
            n_bad++; $display("FAIL good_frame_ok: got %0d want 1", n_ok);
        end
        bad_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i >= xq.size()) bad_d = 1'b1;
            else if (xq[i].d !== exp_d[i] || xq[i].last !== (i == 2)) bad_d = 1'b1;
        end
        n_cmp++;
        if (xq.size() != 3 || bad_d) begin
            n_bad++;
            $display("FAIL good_data: got %0d bytes first %h want 3 bytes A1 A2 A3 last on A3",
                     xq.size(), (xq.size() > 0) ? xq[0].d : 8'hxx);
        end
        n_cmp++;
        if (xq.size() < 3 || xq[0].cyc != ok_cyc ||
            xq[1].cyc != xq[0].cyc + 1 || xq[2].cyc != xq[1].cyc + 1) begin
            n_bad++;
            $display("FAIL good_timing: got size %0d want 3 beats on consecutive cycles from frame_ok",
                     xq.size());
        end
        n_cmp++;
        if (n_chk + n_len + n_to + n_ovr !== 0) begin
            n_bad++;
            $display("FAIL good_no_err: got %0d error pulses want 0",
                     n_chk + n_len + n_to + n_ovr);
        end
    endtask

    task automatic test_bad_chk();
        bit ok;
        clear_mon();
        send_byte(SYNC); send_byte(8'h02);
        send_byte(8'hA1); send_byte(8'hA6); send_byte(8'h06);
        wait_idle(20, ok);
        n_cmp++;
        if (n_chk !== 1 || n_ok !== 0 || xq.size() !== 0 || !ok) begin
            n_bad++;
            $display("FAIL badchk: got chk=%0d ok=%0d beats=%0d want 1 0 0",
                     n_chk, n_ok, xq.size());
        end
        clear_mon();
        send_byte(SYNC); send_byte(8'h01);
        send_byte(8'hA1); send_byte(8'hA0);
        wait_idle(20, ok);
        n_cmp++;
        if (n_ok !== 1 || xq.size() !== 1 || n_chk !== 0) begin
            n_bad++;
            $display("FAIL badchk_next_frame: got ok=%0d beats=%0d want 1 1",
                     n_ok, xq.size());
        end else begin
            n_cmp++;
            if (xq[0].d !== 8'hA1 || xq[0].last !== 1'b1) begin
                n_bad++;
                $display("FAIL badchk_next_data: got %h last %b want A1 last 1",
                         xq[0].d, xq[0].last);
            end
        end
    endtask

    task automatic test_len_err();
        logic [7:0] bad_len[3];
        bad_len[0] = 8'h00; bad_len[1] = 8'h11; bad_len[2] = SYNC;
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            send_byte(SYNC);
            send_byte(bad_len[i]);
            idle(2);
            n_cmp++;
            if (n_len !== 1 || busy !== 1'b0 || n_ok !== 0) begin
                n_bad++;
                $display("FAIL len_err_%h: got err_len=%0d busy=%b want 1 0",
                         bad_len[i], n_len, busy);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon();
        send_byte(SYNC); send_byte(8'h02); send_byte(8'hA1);
        for (int i = 0; i < TO_CLKS + 20 && n_to == 0; i++) idle(1);
        idle(2);
        n_cmp++;
        if (n_to !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: got %0d pulses busy=%b want 1 0", n_to, busy);
        end
        n_cmp++;
        if (to_cyc - last_strobe < TO_CLKS - 1 || to_cyc - last_strobe > TO_CLKS + 1) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d clks want %0d +-1",
                     to_cyc - last_strobe, TO_CLKS);
        end
        clear_mon();
        send_byte(SYNC);
        idle(TO_CLKS + 20);
        n_cmp++;
        if (n_to !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_in_len: got %0d pulses busy=%b want 1 0", n_to, busy);
        end
        clear_mon();
        send_byte(SYNC); send_byte(8'h02); send_byte(8'hA1);
        idle(TO_CLKS - 2);
        send_byte(8'hA2);
        send_byte(8'h01);
        wait_idle(20, ok);
        n_cmp++;
        if (n_to !== 0 || n_ok !== 1 || xq.size() !== 2) begin
            n_bad++;
            $display("FAIL timeout_byte_wins: got to=%0d ok=%0d beats=%0d want 0 1 2",
                     n_to, n_ok, xq.size());
        end
    endtask

    task automatic test_backpressure();
        int unstable;
        bit ok;
        clear_mon();
        unstable = 0;
        m_ready = 1'b0;
        send_byte(SYNC); send_byte(8'h03);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA3);
        for (int i = 0; i < TO_CLKS + 50; i++) begin
            if (i == 20) send_byte(SYNC);
            else idle(1);
            if (m_valid !== 1'b1 || m_data !== 8'hA1 || m_last !== 1'b0) unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (m_data %h)",
                     unstable, m_data);
        end
        n_cmp++;
        if (n_ovr !== 1 || n_to !== 0 || n_ok !== 1) begin
            n_bad++;
            $display("FAIL bp_overrun: got ovr=%0d to=%0d ok=%0d want 1 0 1",
                     n_ovr, n_to, n_ok);
        end
        m_ready = 1'b1;
        wait_idle(20, ok);
        n_cmp++;
        if (xq.size() !== 3 || !ok) begin
            n_bad++;
            $display("FAIL bp_drain: got %0d beats want 3", xq.size());
        end else begin
            n_cmp++;
            if (xq[0].d !== 8'hA1 || xq[1].d !== 8'hA2 ||
                xq[2].d !== 8'hA3 || xq[2].last !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_data: got %h %h %h want A1 A2 A3",
                         xq[0].d, xq[1].d, xq[2].d);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_sync_lost: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        send_byte(SYNC); send_byte(8'h02); send_byte(8'hA1);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_data, m_valid, m_last, frame_ok, err_chk, err_len,
             err_timeout, overrun, busy} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %h want 0000",
                     {m_data, m_valid, m_last, frame_ok, err_chk, err_len,
                      err_timeout, overrun, busy});
        end
        idle(2);
        rst = 1'b0;
        idle(TO_CLKS + 10);
        n_cmp++;
        if (n_ok + n_chk + n_len + n_to + n_ovr !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_no_pulse: got %0d pulses want 0",
                     n_ok + n_chk + n_len + n_to + n_ovr);
        end
        send_byte(SYNC); send_byte(8'h01); send_byte(8'hA2); send_byte(8'hA3);
        wait_idle(20, ok);
        n_cmp++;
        if (n_ok !== 1 || xq.size() !== 1) begin
            n_bad++;
            $display("FAIL rst_mid_next: got ok=%0d beats=%0d want 1 1", n_ok, xq.size());
        end else begin
            n_cmp++;
            if (xq[0].d !== 8'hA2) begin
                n_bad++;
                $display("FAIL rst_mid_data: got %h want A2", xq[0].d);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pl[$];
        logic [8:0] eq[$];
        logic [7:0] c;
        int e_ok, e_chk, e_len, len, stuck, badb;
        e_ok = 0; e_chk = 0; e_len = 0; stuck = 0; badb = 0;
        clear_mon();
        for (int f = 0; f < 40; f++) begin
            len = (f == 0) ? 1 : (f == 1) ? MAXL : int'($urandom_range(0, MAXL + 2));
            send_byte(SYNC);
            send_byte(8'(len));
            if (len == 0 || len > MAXL) begin
                e_len++;
            end else begin
                c = 8'(len);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send_byte(pl[i]);
                    c = c ^ pl[i];
                end
                if ($urandom_range(0, 3) == 0) begin
                    c = c ^ 8'($urandom_range(1, 255));
                    e_chk++;
                end else begin
                    e_ok++;
                    for (int i = 0; i < len; i++) eq.push_back({1'(i == len - 1), pl[i]});
                end
                send_byte(c);
            end
            for (int k = 0; k < 400 && busy; k++) begin
                m_ready = 1'($urandom_range(0, 1));
                idle(1);
            end
            if (busy) stuck++;
            m_ready = 1'b1;
            idle(2);
        end
        n_cmp++;
        if (stuck !== 0) begin
            n_bad++; $display("FAIL rand_stuck: got %0d stuck frames want 0", stuck);
        end
        n_cmp++;
        if (n_ok !== e_ok || n_chk !== e_chk || n_len !== e_len) begin
            n_bad++;
            $display("FAIL rand_counts: got ok/chk/len %0d/%0d/%0d want %0d/%0d/%0d",
                     n_ok, n_chk, n_len, e_ok, e_chk, e_len);
        end
        n_cmp++;
        if (n_to !== 0 || n_ovr !== 0) begin
            n_bad++;
            $display("FAIL rand_spurious: got to=%0d ovr=%0d want 0 0", n_to, n_ovr);
        end
        for (int i = 0; i < eq.size() && i < xq.size(); i++) begin
            if ({xq[i].last, xq[i].d} !== eq[i]) badb++;
        end
        n_cmp++;
        if (xq.size() !== eq.size() || badb !== 0) begin
            n_bad++;
            $display("FAIL rand_data: got %0d beats (%0d wrong) want %0d beats",
                     xq.size(), badb, eq.size());
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (n_multi !== 0) begin
            n_bad++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_multi);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_ready  = 1'b0;
        clear_mon();
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_err();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
